// File: rtl/qspi_fetch_buffer.sv
// Instruction prefetch buffer in front of a QSPI flash read controller.
// Starts one streaming read per branch and captures one 16-bit word per
// contiguous data_ready run into a small FIFO. Each word is byte-swapped into
// a little-endian halfword and presented to the CPU together with its PC.
module qspi_fetch_buffer #(
    parameter int ADDR_BITS = 24,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 branch,
    input  logic [ADDR_BITS-1:0] branch_addr,
    output logic [15:0]          instr_out,
    output logic [ADDR_BITS-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ack,
    output logic [ADDR_BITS-1:0] fc_addr,
    output logic                 fc_start_read,
    output logic                 fc_stall_read,
    output logic                 fc_stop_read,
    input  logic [15:0]          fc_data,
    input  logic                 fc_data_ready,
    input  logic                 fc_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FLUSH, START, STREAM} state_t;

    state_t                 state_reg, state_next;
    logic [15:0]            mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [ADDR_BITS-1:0]   head_pc_reg, fetch_addr_reg;
    logic                   rdy_prev_reg;
    logic [ADDR_BITS-1:0]   branch_target;
    logic                   wr_en, rd_en;

    // Halfword fetch only: bit 0 of the branch target is forced low.
    assign branch_target = {branch_addr[ADDR_BITS-1:1], 1'b0};

    // A branch suppresses both the capture and the pop of the same cycle.
    assign wr_en = (state_reg == STREAM) && fc_data_ready && !rdy_prev_reg && !branch;
    assign rd_en = instr_ack && (count_reg != '0) && !branch;

    // Stall one entry early so a word already in flight always has a slot.
    assign fc_stall_read = (count_reg >= CNT_W'(DEPTH - 1));
    assign fc_stop_read  = (state_reg == FLUSH);
    assign fc_start_read = (state_reg == START);
    assign fc_addr       = fetch_addr_reg;

    assign instr_valid = (count_reg != '0);
    assign instr_out   = mem[rd_ptr_reg];
    assign instr_pc    = head_pc_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a branch overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            FLUSH:   state_next = START;
            START:   state_next = STREAM;
            STREAM:  state_next = STREAM;
            default: state_next = IDLE;
        endcase
        if (branch) begin
            state_next = fc_busy ? FLUSH : START;
        end
    end

    // Edge detector on data_ready so a ready held high during a stall
    // is captured only once.
    always_ff @(posedge clk) begin
        if (!rstn || branch || state_reg == FLUSH) begin
            rdy_prev_reg <= 1'b0;
        end else begin
            rdy_prev_reg <= fc_data_ready;
        end
    end

    // FIFO storage; the controller's first byte lands in the low byte.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {fc_data[7:0], fc_data[15:8]};
        end
    end

    // FIFO pointers, occupancy and fetch/head addresses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_pc_reg    <= '0;
            fetch_addr_reg <= '0;
        end else if (branch) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_pc_reg    <= branch_target;
            fetch_addr_reg <= branch_target;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                head_pc_reg <= head_pc_reg + ADDR_BITS'(2);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_fetch_buffer.sv
// Bench for qspi_fetch_buffer: directed controller stimulus, expected
// halfword/PC pairs queued at issue and checked by a monitor on each pop.
module tb_qspi_fetch_buffer;

    localparam int AB = 24;

    logic          clk = 1'b0;
    logic          rstn;
    logic          branch;
    logic [AB-1:0] branch_addr;
    logic [15:0]   instr_out;
    logic [AB-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ack;
    logic [AB-1:0] fc_addr;
    logic          fc_start_read;
    logic          fc_stall_read;
    logic          fc_stop_read;
    logic [15:0]   fc_data;
    logic          fc_data_ready;
    logic          fc_busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [15:0]   data;
        logic [AB-1:0] pc;
    } exp_t;

    exp_t          exp_q[$];
    logic [AB-1:0] wr_pc;

    qspi_fetch_buffer #(.ADDR_BITS(AB), .DEPTH(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .branch        (branch),
        .branch_addr   (branch_addr),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack),
        .fc_addr       (fc_addr),
        .fc_start_read (fc_start_read),
        .fc_stall_read (fc_stall_read),
        .fc_stop_read  (fc_stop_read),
        .fc_data       (fc_data),
        .fc_data_ready (fc_data_ready),
        .fc_busy       (fc_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && instr_valid && instr_ack && !branch) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL pop: got data 0x%04h pc 0x%06h but no entry expected", instr_out, instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (instr_out !== e.data || instr_pc !== e.pc) begin
                    mismatched++;
                    $display("FAIL pop: got data 0x%04h pc 0x%06h expected data 0x%04h pc 0x%06h",
                             instr_out, instr_pc, e.data, e.pc);
                end else begin
                    $display("ok   pop: data 0x%04h pc 0x%06h", instr_out, instr_pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Branch request for one cycle; discards all queued expectations.
    task automatic do_branch(input logic [AB-1:0] addr, input logic busy);
        branch      = 1'b1;
        branch_addr = addr;
        fc_busy     = busy;
        exp_q.delete();
        wr_pc       = {addr[AB-1:1], 1'b0};
        step();
        branch  = 1'b0;
        fc_busy = 1'b0;
    endtask

    // One controller word: ready held for 'hold' cycles then dropped.
    task automatic deliver(input logic [15:0] w, input logic [15:0] swapped, input int hold);
        exp_t e;
        e.data = swapped;
        e.pc   = wr_pc;
        exp_q.push_back(e);
        wr_pc   = wr_pc + AB'(2);
        fc_busy = 1'b1;
        fc_data = w;
        fc_data_ready = 1'b1;
        repeat (hold) step();
        fc_data_ready = 1'b0;
        step();
    endtask

    task automatic ack(input int n);
        instr_ack = 1'b1;
        repeat (n) step();
        instr_ack = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; branch = 1'b0; branch_addr = '0; instr_ack = 1'b0;
        fc_data = '0; fc_data_ready = 1'b0; fc_busy = 1'b0; wr_pc = '0;
        repeat (3) step();
        rstn = 1'b1;
        step();

        // Reset state; nothing starts without a branch.
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_start", 32'(fc_start_read), 32'h0);
        chk("rst_stop",  32'(fc_stop_read), 32'h0);
        chk("rst_stall", 32'(fc_stall_read), 32'h0);
        chk("rst_addr",  32'(fc_addr), 32'h0);
        chk("rst_pc",    32'(instr_pc), 32'h0);

        // Basic fetch with odd branch address.
        do_branch(24'h000101, 1'b0);
        chk("t1_start", 32'(fc_start_read), 32'h1);
        chk("t1_addr",  32'(fc_addr), 32'h000100);
        chk("t1_pc",    32'(instr_pc), 32'h000100);
        step();
        chk("t1_start_one", 32'(fc_start_read), 32'h0);
        deliver(16'h1337, 16'h3713, 1);
        deliver(16'hABCD, 16'hCDAB, 2);
        ack(2);
        chk("t1_empty", 32'(instr_valid), 32'h0);

        // Fill to stall threshold, hold ready through the stall.
        deliver(16'h0A0B, 16'h0B0A, 1);
        deliver(16'h1C1D, 16'h1D1C, 1);
        chk("t2_stall_at2", 32'(fc_stall_read), 32'h0);
        deliver(16'h2E2F, 16'h2F2E, 1);
        chk("t2_stall_at3", 32'(fc_stall_read), 32'h1);
        deliver(16'h4041, 16'h4140, 5);
        chk("t2_stall_at4", 32'(fc_stall_read), 32'h1);
        ack(2);
        chk("t2_stall_drop", 32'(fc_stall_read), 32'h0);
        deliver(16'h5051, 16'h5150, 1);
        ack(3);
        chk("t2_empty", 32'(instr_valid), 32'h0);

        // Branch while controller busy with two entries buffered.
        deliver(16'h6061, 16'h6160, 1);
        deliver(16'h7071, 16'h7170, 1);
        chk("t3_full2", 32'(instr_valid), 32'h1);
        do_branch(24'h002000, 1'b1);
        chk("t3_valid", 32'(instr_valid), 32'h0);
        chk("t3_stop",  32'(fc_stop_read), 32'h1);
        chk("t3_nostart", 32'(fc_start_read), 32'h0);
        step();
        chk("t3_stop_one", 32'(fc_stop_read), 32'h0);
        chk("t3_start", 32'(fc_start_read), 32'h1);
        chk("t3_addr",  32'(fc_addr), 32'h002000);
        step();
        deliver(16'h5566, 16'h6655, 1);
        ack(1);

        // Branch coinciding with data_ready rising edge and ack.
        deliver(16'h0102, 16'h0201, 1);
        fc_data = 16'h7788;
        fc_data_ready = 1'b1;
        instr_ack = 1'b1;
        do_branch(24'h003000, 1'b0);
        fc_data_ready = 1'b0;
        instr_ack = 1'b0;
        chk("t4_valid", 32'(instr_valid), 32'h0);
        chk("t4_pc",    32'(instr_pc), 32'h003000);
        chk("t4_start", 32'(fc_start_read), 32'h1);
        step();
        chk("t4_still_empty", 32'(instr_valid), 32'h0);

        // Re-branch during FLUSH: latest target wins.
        do_branch(24'h000080, 1'b1);
        chk("t5_stop", 32'(fc_stop_read), 32'h1);
        do_branch(24'h000040, 1'b0);
        chk("t5_start", 32'(fc_start_read), 32'h1);
        chk("t5_addr",  32'(fc_addr), 32'h000040);
        step();

        // PC wrap at top of address space, then ack on empty ignored.
        do_branch(24'hFFFFFE, 1'b0);
        step();
        deliver(16'hA1A2, 16'hA2A1, 1);
        deliver(16'hB1B2, 16'hB2B1, 1);
        ack(2);
        chk("t6_empty", 32'(instr_valid), 32'h0);
        ack(1);
        chk("t6_pc_after_empty_ack", 32'(instr_pc), 32'h000002);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
